// File: rtl/arcade_input_cond.sv
// rtl/arcade_input_cond.sv - player control conditioning: sync, debounce, SOCD, coin pulse shaping
//
// Purpose:
//   Sits between the joystick source mux and the arcade core. Every raw
//   control bit is synchronised and debounced on a slow prescaled tick.
//   Opposing directions cancel. Coin presses become fixed-width active-low
//   pulses with a guaranteed gap, and one extra press can wait in a queue.
//
// Ports:
//   clk_sys     system clock, all logic on the rising edge
//   reset       synchronous, active-high
//   joy_in      raw active-high {coin,start2,start1,bomb,fire,up,down,left,right}
//   btn_n       debounced, SOCD-filtered, active-low {start2..right}
//   coin_n      active-low shaped coin pulse
//   coin_count  credits issued, saturating at 16'hFFFF
//   tick        prescaler tick, one cycle wide

module arcade_input_cond #(
    parameter int PRESCALE         = 2000,
    parameter int DEB_TICKS        = 8,
    parameter int COIN_PULSE_TICKS = 40,
    parameter int COIN_GAP_TICKS   = 40
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [8:0]  joy_in,
    output logic [7:0]  btn_n,
    output logic        coin_n,
    output logic [15:0] coin_count,
    output logic        tick
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [7:0]    DEB_LAST   = 8'(DEB_TICKS - 1);
    localparam logic [15:0]   PULSE_LAST = 16'(COIN_PULSE_TICKS - 1);
    localparam logic [15:0]   GAP_LAST   = 16'(COIN_GAP_TICKS - 1);

    // Bit positions inside joy_in / stable
    localparam int B_RIGHT = 0;
    localparam int B_LEFT  = 1;
    localparam int B_DOWN  = 2;
    localparam int B_UP    = 3;
    localparam int B_COIN  = 8;

    // ------------------------------------------------------------------
    // Prescaler
    // ------------------------------------------------------------------
    logic [PW-1:0] presc;

    assign tick = (presc == PRESC_LAST);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Two-flop synchroniser
    // ------------------------------------------------------------------
    logic [8:0] sync1;
    logic [8:0] sync2;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= joy_in;
            sync2 <= sync1;
        end
    end

    // ------------------------------------------------------------------
    // Debounce: a bit must disagree with its stable value on DEB_TICKS
    // consecutive ticks. Any cycle of agreement restarts the count, so a
    // glitch shorter than that window never reaches the stable value.
    // ------------------------------------------------------------------
    logic [8:0] stable;
    logic [7:0] deb_cnt [9];

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            stable <= '0;
            for (int i = 0; i < 9; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 9; i++) begin
                if (sync2[i] == stable[i]) begin
                    deb_cnt[i] <= '0;
                end else if (tick) begin
                    if (deb_cnt[i] == DEB_LAST) begin
                        stable[i]  <= sync2[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + 1'b1;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // SOCD: opposing directions held together both read as released
    // ------------------------------------------------------------------
    logic [7:0] filt;

    always_comb begin
        filt = stable[7:0];
        if (stable[B_LEFT] && stable[B_RIGHT]) begin
            filt[B_LEFT]  = 1'b0;
            filt[B_RIGHT] = 1'b0;
        end
        if (stable[B_UP] && stable[B_DOWN]) begin
            filt[B_UP]   = 1'b0;
            filt[B_DOWN] = 1'b0;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            btn_n <= 8'hFF;
        end else begin
            btn_n <= ~filt;
        end
    end

    // ------------------------------------------------------------------
    // Coin edge detect
    // ------------------------------------------------------------------
    logic stable_d;
    logic coin_rise;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            stable_d <= 1'b0;
        end else begin
            stable_d <= stable[B_COIN];
        end
    end

    assign coin_rise = stable[B_COIN] & ~stable_d;

    // ------------------------------------------------------------------
    // Coin pulse FSM with one-deep pending queue and saturating counter
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } coin_state_t;

    coin_state_t state;
    logic [15:0] cnt;
    logic        pending;
    logic [15:0] count_q;
    logic [15:0] count_inc;

    assign count_inc  = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
    assign coin_count = count_q;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state   <= IDLE;
            coin_n  <= 1'b1;
            cnt     <= '0;
            pending <= 1'b0;
            count_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    coin_n <= 1'b1;
                    if (coin_rise) begin
                        state   <= PULSE;
                        coin_n  <= 1'b0;
                        cnt     <= PULSE_LAST;
                        count_q <= count_inc;
                    end
                end

                PULSE: begin
                    // A rise while a credit is already waiting is dropped
                    if (coin_rise) begin
                        pending <= 1'b1;
                    end
                    if (tick) begin
                        if (cnt == '0) begin
                            state  <= GAP;
                            coin_n <= 1'b1;
                            cnt    <= GAP_LAST;
                        end else begin
                            cnt <= cnt - 16'd1;
                        end
                    end
                end

                GAP: begin
                    if (tick && cnt == '0) begin
                        if (pending) begin
                            // A rise on this very cycle becomes the next queued credit
                            state   <= PULSE;
                            coin_n  <= 1'b0;
                            cnt     <= PULSE_LAST;
                            pending <= coin_rise;
                            count_q <= count_inc;
                        end else if (coin_rise) begin
                            // Gap already satisfied: start straight away, nothing lost
                            state   <= PULSE;
                            coin_n  <= 1'b0;
                            cnt     <= PULSE_LAST;
                            count_q <= count_inc;
                        end else begin
                            state  <= IDLE;
                            coin_n <= 1'b1;
                        end
                    end else begin
                        if (coin_rise) begin
                            pending <= 1'b1;
                        end
                        if (tick) begin
                            cnt <= cnt - 16'd1;
                        end
                    end
                end

                default: begin
                    state   <= IDLE;
                    coin_n  <= 1'b1;
                    pending <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arcade_input_cond.sv
// tb/tb_arcade_input_cond.sv - scoreboard bench for arcade_input_cond

module tb_arcade_input_cond;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [8:0]  joy;
    logic [8:0]  joy_f;
    logic [7:0]  btn_n;
    logic        coin_n;
    logic [15:0] coin_count;
    logic        tick;
    logic [7:0]  fbtn_n;
    logic        fcoin_n;
    logic [15:0] fcoin_count;
    logic        ftick;

    always #5 clk_sys = ~clk_sys;

    arcade_input_cond #(
        .PRESCALE(4), .DEB_TICKS(3), .COIN_PULSE_TICKS(5), .COIN_GAP_TICKS(5)
    ) dut (
        .clk_sys(clk_sys), .reset(reset), .joy_in(joy), .btn_n(btn_n),
        .coin_n(coin_n), .coin_count(coin_count), .tick(tick)
    );

    // Short debounce lets coin rises come close enough to hit a busy queue
    arcade_input_cond #(
        .PRESCALE(4), .DEB_TICKS(1), .COIN_PULSE_TICKS(5), .COIN_GAP_TICKS(5)
    ) u_fast (
        .clk_sys(clk_sys), .reset(reset), .joy_in(joy_f), .btn_n(fbtn_n),
        .coin_n(fcoin_n), .coin_count(fcoin_count), .tick(ftick)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always @(posedge clk_sys) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act >= lo && act <= hi) n_pass++;
        else $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    endtask

    task automatic fail_event(input string name);
        n_checks++;
        $display("FAIL %s: got unexpected output event expected none", name);
    endtask

    typedef struct { logic [7:0] val; int t; } btn_exp_t;
    typedef struct { int width; int gap; logic [15:0] count; } coin_exp_t;

    btn_exp_t  btn_q[$];
    coin_exp_t coin_q[$];
    coin_exp_t fcoin_q[$];
    bit        coin_mon_en = 1'b1;

    // Button monitor: every btn_n change must match the next expected value
    // and arrive within sync + debounce + output latency of the raw change.
    logic [7:0] btn_prev = 8'hFF;
    always @(negedge clk_sys) begin
        if (!reset && btn_n !== btn_prev) begin
            if (btn_q.size() == 0) begin
                fail_event("btn_unexpected");
            end else begin
                check("btn_val", 32'(btn_n), 32'(btn_q[0].val));
                check_range("btn_latency", cyc - btn_q[0].t, 11, 18);
                void'(btn_q.pop_front());
            end
            btn_prev <= btn_n;
        end
    end

    // Coin monitor: widths counted in negedge samples
    logic coin_prev = 1'b1;
    int   low_cnt   = 0;
    int   high_cnt  = 0;
    always @(negedge clk_sys) begin
        coin_prev <= coin_n;
        if (coin_n == 1'b0) low_cnt <= low_cnt + 1;
        else                high_cnt <= high_cnt + 1;
        if (coin_prev && !coin_n) begin
            low_cnt <= 1;
            if (coin_mon_en && coin_q.size() > 0 && coin_q[0].gap != 0)
                check("coin_gap", 32'(high_cnt), 32'(coin_q[0].gap));
        end
        if (!coin_prev && coin_n) begin
            high_cnt <= 1;
            if (coin_mon_en) begin
                if (coin_q.size() == 0) begin
                    fail_event("coin_unexpected");
                end else begin
                    check("coin_width", 32'(low_cnt), 32'(coin_q[0].width));
                    check("coin_count", 32'(coin_count), 32'(coin_q[0].count));
                    void'(coin_q.pop_front());
                end
            end
        end
    end

    logic fcoin_prev = 1'b1;
    int   flow_cnt   = 0;
    int   fhigh_cnt  = 0;
    always @(negedge clk_sys) begin
        fcoin_prev <= fcoin_n;
        if (fcoin_n == 1'b0) flow_cnt <= flow_cnt + 1;
        else                 fhigh_cnt <= fhigh_cnt + 1;
        if (fcoin_prev && !fcoin_n) begin
            flow_cnt <= 1;
            if (fcoin_q.size() > 0 && fcoin_q[0].gap != 0)
                check("fast_coin_gap", 32'(fhigh_cnt), 32'(fcoin_q[0].gap));
        end
        if (!fcoin_prev && fcoin_n) begin
            fhigh_cnt <= 1;
            if (fcoin_q.size() == 0) begin
                fail_event("fast_coin_unexpected");
            end else begin
                check("fast_coin_width", 32'(flow_cnt), 32'(fcoin_q[0].width));
                check("fast_coin_count", 32'(fcoin_count), 32'(fcoin_q[0].count));
                void'(fcoin_q.pop_front());
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic push_btn(input logic [7:0] v);
        btn_q.push_back('{val: v, t: cyc});
    endtask

    task automatic coin_press(input int hold, input int after);
        joy[8] = 1'b1;
        wait_cyc(hold);
        joy[8] = 1'b0;
        wait_cyc(after);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1;
        joy   = '0;
        joy_f = '0;
        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        reset = 1'b0;

        check("rst_btn_n", 32'(btn_n), 32'hFF);
        check("rst_coin_n", 32'(coin_n), 32'h1);
        check("rst_coin_count", 32'(coin_count), 32'h0);
        check("rst_tick", 32'(tick), 32'h0);

        // Prescaler counts 1,2,3 over the next three edges; tick on the third
        n = 0;
        do begin
            @(negedge clk_sys);
            n++;
        end while (!tick && n < 10);
        check("first_tick", 32'(n), 32'd3);

        // Fire glitch of 8 cycles spans only 2 ticks: rejected
        joy[4] = 1'b1;
        wait_cyc(8);
        joy[4] = 1'b0;
        wait_cyc(30);
        check("fire_glitch", 32'(btn_n), 32'hFF);

        // Fire held: accepted, then released
        push_btn(8'hEF);
        joy[4] = 1'b1;
        wait_cyc(20);
        push_btn(8'hFF);
        joy[4] = 1'b0;
        wait_cyc(30);

        // SOCD left+right cancel, dropping right leaves left
        joy[1:0] = 2'b11;
        wait_cyc(30);
        check("socd_lr", 32'(btn_n), 32'hFF);
        push_btn(8'hFD);
        joy[0] = 1'b0;
        wait_cyc(30);
        push_btn(8'hFF);
        joy[1] = 1'b0;
        wait_cyc(30);

        // SOCD up+down cancel, dropping up leaves down
        joy[3:2] = 2'b11;
        wait_cyc(30);
        check("socd_ud", 32'(btn_n), 32'hFF);
        push_btn(8'hFB);
        joy[3] = 1'b0;
        wait_cyc(30);
        push_btn(8'hFF);
        joy[2] = 1'b0;
        wait_cyc(30);

        // Single coin held long: one pulse (first pulse starts a cycle after a tick)
        coin_q.push_back('{width: 19, gap: 0, count: 16'd1});
        coin_press(200, 60);
        check("single_count", 32'(coin_count), 32'd1);

        // Second press lands in GAP: queued, follows after a full gap
        coin_q.push_back('{width: 19, gap: 0, count: 16'd2});
        coin_q.push_back('{width: 20, gap: 20, count: 16'd3});
        coin_press(16, 16);
        coin_press(16, 120);
        check("queued_count", 32'(coin_count), 32'd3);

        // Three rises 16 cycles apart: second queues during PULSE, third dropped in GAP
        fcoin_q.push_back('{width: 19, gap: 0, count: 16'd1});
        fcoin_q.push_back('{width: 20, gap: 20, count: 16'd2});
        repeat (3) begin
            joy_f[8] = 1'b1;
            wait_cyc(8);
            joy_f[8] = 1'b0;
            wait_cyc(8);
        end
        wait_cyc(100);
        check("fast_drop_count", 32'(fcoin_count), 32'd2);

        // Saturation
        force dut.count_q = 16'hFFFE;
        @(negedge clk_sys);
        release dut.count_q;
        @(negedge clk_sys);
        check("sat_preload", 32'(coin_count), 32'hFFFE);
        repeat (3) begin
            coin_q.push_back('{width: 19, gap: 0, count: 16'hFFFF});
            coin_press(16, 80);
        end
        check("sat_count", 32'(coin_count), 32'hFFFF);

        // Reset in the middle of a pulse
        coin_mon_en = 1'b0;
        joy[8] = 1'b1;
        n = 0;
        while (coin_n !== 1'b0 && n < 40) begin
            @(negedge clk_sys);
            n++;
        end
        check("midpulse_reached", 32'(coin_n), 32'h0);
        wait_cyc(4);
        reset  = 1'b1;
        joy[8] = 1'b0;
        @(negedge clk_sys);
        check("midpulse_coin_n", 32'(coin_n), 32'h1);
        check("midpulse_count", 32'(coin_count), 32'h0);
        wait_cyc(2);
        reset = 1'b0;
        n = 0;
        repeat (40) begin
            @(negedge clk_sys);
            if (coin_n == 1'b0) n++;
        end
        check("post_reset_idle", 32'(n), 32'd0);
        coin_mon_en = 1'b1;

        check("btn_q_empty", 32'(btn_q.size()), 32'd0);
        check("coin_q_empty", 32'(coin_q.size()), 32'd0);
        check("fcoin_q_empty", 32'(fcoin_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
